// File: rtl/pc_stack_unit.sv
// Program counter with branch/call/return sequencing and a small LIFO
// return-address stack that reports sticky overflow/underflow.
module pc_stack_unit #(
    parameter int PC_WIDTH    = 8,
    parameter int STACK_DEPTH = 4,
    parameter int DEPTH_WIDTH = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   zeroFlag,
    input  logic                   isBranch,
    input  logic                   isBranchEqual,
    input  logic                   isBranchNotEqual,
    input  logic                   isCall,
    input  logic                   isReturn,
    input  logic [PC_WIDTH-1:0]    immediate_address,
    output logic [PC_WIDTH-1:0]    PC,
    output logic [DEPTH_WIDTH-1:0] stackDepth,
    output logic                   stackOverflow,
    output logic                   stackUnderflow
);

    localparam logic [PC_WIDTH-1:0]    PC_ONE    = PC_WIDTH'(1);
    localparam logic [DEPTH_WIDTH-1:0] DEPTH_ONE = DEPTH_WIDTH'(1);
    localparam logic [DEPTH_WIDTH-1:0] DEPTH_MAX = DEPTH_WIDTH'(STACK_DEPTH);

    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [DEPTH_WIDTH-1:0] depth_q, depth_d;
    logic                   ovf_q, ovf_d;
    logic                   unf_q, unf_d;
    logic [PC_WIDTH-1:0]    stack_q [STACK_DEPTH];
    logic [PC_WIDTH-1:0]    stack_d [STACK_DEPTH];

    logic [PC_WIDTH-1:0]    pc_inc;
    logic [PC_WIDTH-1:0]    top_entry;
    logic                   push;
    logic                   stack_empty;
    logic                   stack_full;

    assign pc_inc      = pc_q + PC_ONE;
    assign stack_empty = (depth_q == '0);
    assign stack_full  = (depth_q == DEPTH_MAX);

    always_comb begin
        top_entry = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (depth_q == DEPTH_WIDTH'(i + 1)) top_entry = stack_q[i];
        end
    end

    // Return beats call beats branch; a suppressed call/return still advances PC.
    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        if (!stall) begin
            pc_d = pc_inc;
            if (isReturn) begin
                if (!stack_empty) begin
                    pc_d    = top_entry;
                    depth_d = depth_q - DEPTH_ONE;
                end else begin
                    unf_d = 1'b1;
                end
            end else if (isCall) begin
                if (!stack_full) begin
                    push    = 1'b1;
                    pc_d    = immediate_address;
                    depth_d = depth_q + DEPTH_ONE;
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (isBranch) begin
                if (isBranchEqual && isBranchNotEqual) begin
                    pc_d = pc_inc;
                end else if (isBranchEqual) begin
                    if (zeroFlag) pc_d = pc_q + immediate_address;
                end else if (isBranchNotEqual) begin
                    if (!zeroFlag) pc_d = pc_q + immediate_address;
                end else begin
                    pc_d = immediate_address;
                end
            end
        end
    end

    // The slot at the current depth is the next free one, so a pop then push reuses it.
    for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_entry
        assign stack_d[gi] = (push && depth_q == DEPTH_WIDTH'(gi)) ? pc_inc : stack_q[gi];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q    <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= stack_d[i];
        end
    end

    assign PC             = pc_q;
    assign stackDepth     = depth_q;
    assign stackOverflow  = ovf_q;
    assign stackUnderflow = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed and random checks of pc_stack_unit against a queue-based model.
module tb_pc_stack_unit;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       stall = 1'b0;
    logic       zeroFlag = 1'b0;
    logic       isBranch = 1'b0;
    logic       isBranchEqual = 1'b0;
    logic       isBranchNotEqual = 1'b0;
    logic       isCall = 1'b0;
    logic       isReturn = 1'b0;
    logic [7:0] immediate_address = '0;
    logic [7:0] PC;
    logic [2:0] stackDepth;
    logic       stackOverflow;
    logic       stackUnderflow;

    pc_stack_unit #(.PC_WIDTH(8), .STACK_DEPTH(4), .DEPTH_WIDTH(3)) dut (
        .clock(clock), .reset(reset), .stall(stall), .zeroFlag(zeroFlag),
        .isBranch(isBranch), .isBranchEqual(isBranchEqual),
        .isBranchNotEqual(isBranchNotEqual), .isCall(isCall), .isReturn(isReturn),
        .immediate_address(immediate_address), .PC(PC), .stackDepth(stackDepth),
        .stackOverflow(stackOverflow), .stackUnderflow(stackUnderflow)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: PC as an integer, return addresses in a queue.
    int m_pc;
    int m_stack[$];
    bit m_ovf, m_unf;

    task automatic model_reset();
        m_pc = 0;
        m_stack.delete();
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, "_pc"}, 32'(PC), m_pc);
        check({tag, "_depth"}, 32'(stackDepth), m_stack.size());
        check({tag, "_ovf"}, 32'(stackOverflow), 32'(m_ovf));
        check({tag, "_unf"}, 32'(stackUnderflow), 32'(m_unf));
    endtask

    task automatic model_step(input bit st, zf, br, beq, bne, cl, rt, input int imm);
        int off;
        off = (imm >= 128) ? imm - 256 : imm;
        if (st) return;
        if (rt) begin
            if (m_stack.size() > 0) m_pc = m_stack.pop_back();
            else begin m_pc = (m_pc + 1) % 256; m_unf = 1; end
        end else if (cl) begin
            if (m_stack.size() < 4) begin
                m_stack.push_back((m_pc + 1) % 256);
                m_pc = imm;
            end else begin
                m_pc = (m_pc + 1) % 256;
                m_ovf = 1;
            end
        end else if (br) begin
            if (beq && bne)          m_pc = (m_pc + 1) % 256;
            else if (beq)            m_pc = zf ? ((m_pc + off) & 255) : (m_pc + 1) % 256;
            else if (bne)            m_pc = !zf ? ((m_pc + off) & 255) : (m_pc + 1) % 256;
            else                     m_pc = imm;
        end else begin
            m_pc = (m_pc + 1) % 256;
        end
    endtask

    task automatic step(input string tag, input bit st, zf, br, beq, bne, cl, rt,
                        input logic [7:0] imm);
        stall = st; zeroFlag = zf; isBranch = br; isBranchEqual = beq;
        isBranchNotEqual = bne; isCall = cl; isReturn = rt; immediate_address = imm;
        model_step(st, zf, br, beq, bne, cl, rt, int'(imm));
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);  step(tag, 0, 0, 0, 0, 0, 0, 0, 8'h00); endtask
    task automatic jump(input logic [7:0] a); step("jump", 0, 0, 1, 0, 0, 0, 0, a); endtask
    task automatic call(input logic [7:0] a); step("call", 0, 0, 0, 0, 0, 1, 0, a); endtask
    task automatic ret();                     step("ret", 0, 0, 0, 0, 0, 0, 1, 8'h00); endtask

    initial begin
        model_reset();
        #11;
        check_all("reset");
        reset = 1'b1;

        idle("idle1"); idle("idle2"); idle("idle3");
        check("idle3_pc_const", 32'(PC), 3);

        jump(8'hFF);
        idle("wrap");
        check("wrap_pc_const", 32'(PC), 0);

        jump(8'd10);
        step("beq_taken", 0, 1, 1, 1, 0, 0, 0, 8'hFE);
        check("beq_pc_const", 32'(PC), 8);
        jump(8'd10);
        step("bne_nt", 0, 1, 1, 0, 1, 0, 0, 8'hFE);
        check("bne_pc_const", 32'(PC), 11);
        jump(8'd10);
        step("bne_taken", 0, 0, 1, 0, 1, 0, 0, 8'h05);
        step("both_illegal", 0, 1, 1, 1, 1, 0, 0, 8'h30);
        jump(8'd10);
        jump(8'h40);
        check("abs_pc_const", 32'(PC), 64);

        jump(8'd5);
        call(8'd20);
        check("call_pc_const", 32'(PC), 20);
        ret();
        check("ret_pc_const", 32'(PC), 6);

        call(8'd100); call(8'd110); call(8'd120); call(8'd130); call(8'd140);
        check("ovf_depth_const", 32'(stackDepth), 4);
        check("ovf_flag_const", 32'(stackOverflow), 1);
        check("ovf_pc_const", 32'(PC), 131);
        ret(); check("pop1_const", 32'(PC), 121);
        ret(); check("pop2_const", 32'(PC), 111);
        ret(); check("pop3_const", 32'(PC), 101);
        ret(); check("pop4_const", 32'(PC), 7);

        // Clear sticky flags, then exercise underflow.
        reset = 1'b0; #1; model_reset(); reset = 1'b1;
        jump(8'd7);
        ret();
        check("unf_pc_const", 32'(PC), 8);
        check("unf_flag_const", 32'(stackUnderflow), 1);

        call(8'd50);
        step("call_and_ret", 0, 0, 0, 0, 0, 1, 1, 8'd90);
        check("callret_pc_const", 32'(PC), 9);
        call(8'd40);
        step("stall_call", 1, 0, 0, 0, 0, 1, 0, 8'd77);
        check("stall_pc_const", 32'(PC), 40);

        // Pop then push must reuse the freed slot.
        call(8'd60); ret(); call(8'd70); ret(); ret();

        call(8'd40); call(8'd60); jump(8'd30);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        check("async_pc_const", 32'(PC), 0);
        #1 reset = 1'b1;
        idle("post_reset");

        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 7) == 0), 1'($urandom), ($urandom_range(0, 2) == 0),
                 1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0), 8'($urandom));
            if (i % 97 == 96) begin
                #2 reset = 1'b0; #1 model_reset(); #1 reset = 1'b1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_stack_unit.md
PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 Parameter PC_WIDTH, default 8: width of the program counter and of all address/offset inputs.
REQ-002 Parameter STACK_DEPTH, default 4: number of return-address entries (legal range 1..16).
REQ-003 Parameter DEPTH_WIDTH, default 3: width of the stackDepth output, which SHALL be at least clog2(STACK_DEPTH+1).
REQ-004 Port clock, input, 1: the single clock; all state updates occur on the rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port stall, input, 1: when high, all state is held.
REQ-007 Port zeroFlag, input, 1: ALU zero flag.
REQ-008 Port isBranch, input, 1: the current instruction is a branch.
REQ-009 Port isBranchEqual, input, 1: conditional branch, taken when zeroFlag is 1.
REQ-010 Port isBranchNotEqual, input, 1: conditional branch, taken when zeroFlag is 0.
REQ-011 Port isCall, input, 1: subroutine call to an absolute address.
REQ-012 Port isReturn, input, 1: return to the top-of-stack address.
REQ-013 Port immediate_address, input, PC_WIDTH: absolute target, or signed two's-complement offset for conditional branches.
REQ-014 Port PC, output, PC_WIDTH: current program counter, driven directly from a register.
REQ-015 Port stackDepth, output, DEPTH_WIDTH: number of valid stack entries.
REQ-016 Port stackOverflow, output, 1: sticky flag; a call was attempted while the stack was full.
REQ-017 Port stackUnderflow, output, 1: sticky flag; a return was attempted while the stack was empty.

Function
REQ-018 With stall high, PC, the stack, stackDepth and both flags SHALL hold for that edge, regardless of any other input.
REQ-019 With stall low, each rising edge SHALL apply exactly one action, in this priority order: isReturn, then isCall, then isBranch, then sequential increment.
REQ-020 Increment: PC <= PC+1, modulo 2^PC_WIDTH; 2^PC_WIDTH-1 wraps to 0.
REQ-021 isBranch with both isBranchEqual and isBranchNotEqual low: PC <= immediate_address (absolute jump).
REQ-022 isBranch with isBranchEqual high: if zeroFlag==1, PC <= PC + sign-extended immediate_address, modulo 2^PC_WIDTH; otherwise PC <= PC+1.
REQ-023 isBranch with isBranchNotEqual high: if zeroFlag==0, PC <= PC + immediate_address (signed), modulo 2^PC_WIDTH; otherwise PC <= PC+1.
REQ-024 isBranch with both isBranchEqual and isBranchNotEqual high is illegal: the branch is treated as not taken, giving PC <= PC+1.
REQ-025 isCall with stackDepth < STACK_DEPTH:
- push PC+1 (wrapped) onto the stack;
- stackDepth increments;
- PC <= immediate_address.
REQ-026 isCall with stackDepth == STACK_DEPTH:
- no push; stack contents and stackDepth are unchanged;
- PC <= PC+1 (the call is suppressed);
- stackOverflow <= 1.
REQ-027 isReturn with stackDepth > 0: PC <= top-of-stack entry, the entry is popped, and stackDepth decrements.
REQ-028 isReturn with stackDepth == 0:
- PC <= PC+1;
- stackUnderflow <= 1;
- stackDepth remains 0.
REQ-029 isReturn and isCall high together: the return is executed and the call is ignored, with no push.
REQ-030 The stack SHALL be LIFO, and a pop followed by a push SHALL reuse the freed slot.
REQ-031 stackOverflow and stackUnderflow SHALL clear only on reset.
REQ-032 All outputs SHALL be free of X after reset, and combinational inputs SHALL NOT reach the outputs combinationally.

Reset
REQ-033 While reset is low, the block SHALL asynchronously force:
- PC = 0;
- stackDepth = 0;
- every stack entry = 0;
- stackOverflow = 0 and stackUnderflow = 0.
REQ-034 A reset asserted mid-call or mid-sequence SHALL abort the operation, with no partial push or pop retained.
REQ-035 The first rising edge after reset deasserts SHALL perform a normal action from PC = 0.

Verification
REQ-036 Reset, then 3 idle edges -> PC = 3, stackDepth = 0, both flags 0; with PC_WIDTH=8, starting from PC = 255 an idle edge gives PC = 0.
REQ-037 At PC=10, isBranchEqual with zeroFlag=1 and immediate 8'hFE -> PC = 8. At PC=10, isBranchNotEqual with zeroFlag=1 -> PC = 11. At PC=10, isBranch alone with immediate 8'h40 -> PC = 64.
REQ-038 At PC=5, isCall to 20 -> PC = 20, stackDepth = 1; then an isReturn -> PC = 6, stackDepth = 0.
REQ-039 With STACK_DEPTH=4, 5 consecutive calls -> stackDepth = 4, stackOverflow = 1, and the 5th call advances PC by 1; then 4 returns pop the addresses in LIFO order.
REQ-040 isReturn on an empty stack at PC=7 -> PC = 8 and stackUnderflow = 1; isCall and isReturn together with depth 1 -> pop only; stall high during a call -> no change to any state.
REQ-041 Reset pulsed low asynchronously between edges with depth 2 and PC=30 -> immediately PC = 0, stackDepth = 0, flags 0.
